// File: rtl/host_cmd_pkg.sv
// Shared definitions for the host command port arbiter: FSM state codes,
// command word field positions, target codes and small decode helpers.
package host_cmd_pkg;

  // Arbiter FSM state codes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Command word layout
  localparam int CMD_WR_BIT  = 31;
  localparam int CMD_TGT_MSB = 30;
  localparam int CMD_TGT_LSB = 29;

  // Target codes; any code with the upper bit set addresses the local bus
  localparam logic [1:0] TGT_RPU = 2'b00;
  localparam logic [1:0] TGT_INT = 2'b01;
  localparam logic [1:0] TGT_LB  = 2'b10;

  typedef enum logic [1:0] {
    TARGET_RPU = 2'd0,
    TARGET_INT = 2'd1,
    TARGET_LB  = 2'd2
  } target_e;

  // True when the command word describes a write
  function automatic logic cmd_is_write(input logic [31:0] cmd);
    return cmd[CMD_WR_BIT];
  endfunction

  // Decode the target field, folding both local-bus codes together
  function automatic target_e cmd_target(input logic [31:0] cmd);
    logic [1:0] tgt;
    tgt = cmd[CMD_TGT_MSB:CMD_TGT_LSB];
    if (tgt[1])
      return TARGET_LB;
    else if (tgt == TGT_INT)
      return TARGET_INT;
    else
      return TARGET_RPU;
  endfunction

endpackage

// File: rtl/host_cmd_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or above rr_ptr, wrapping around to index 0. Reusable for any host-port
// sharing block that keeps its own pointer.
module host_cmd_rr_pick
  import host_cmd_pkg::*;
#(
  parameter int REQ_COUNT = 2,
  parameter int REQ_WIDTH = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [REQ_WIDTH-1:0] rr_ptr,
  output logic                 grant_valid,
  output logic [REQ_WIDTH-1:0] grant_idx
);

  // Walk the requesters starting at rr_ptr; the first hit wins
  always_comb begin
    int                 cand_int;
    logic [REQ_WIDTH-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_int    = 0;
    cand        = '0;
    for (int off = 0; off < REQ_COUNT; off++) begin
      cand_int = int'(rr_ptr) + off;
      if (cand_int >= REQ_COUNT)
        cand_int = cand_int - REQ_COUNT;
      cand = REQ_WIDTH'(cand_int);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/host_cmd_arbiter.sv
// Shares the single host command/readback port among REQ_COUNT requesters.
// One command is in flight at a time: it is issued as a one-cycle strobe,
// reads wait a fixed readback latency, and the result is held for the
// winning requester until it takes it.
module host_cmd_arbiter
  import host_cmd_pkg::*;
#(
  parameter int REQ_COUNT  = 2,
  parameter int RD_LATENCY = 16,
  parameter int REQ_WIDTH  = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [REQ_COUNT*32-1:0] req_cmd,
  input  logic [REQ_COUNT*32-1:0] req_wr_data,
  input  logic [REQ_COUNT-1:0]    req_valid,
  output logic [REQ_COUNT-1:0]    req_ready,
  output logic [31:0]             resp_data,
  output logic [REQ_COUNT-1:0]    resp_valid,
  input  logic [REQ_COUNT-1:0]    resp_ready,
  output logic [31:0]             host_cmd,
  output logic [31:0]             host_cmd_wr_data,
  output logic                    host_cmd_valid,
  input  logic [31:0]             host_cmd_rd_data,
  output logic [REQ_WIDTH-1:0]    grant_id,
  output logic                    busy
);

  // The counter only has to hold RD_LATENCY-1
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [REQ_WIDTH-1:0] LAST_IDX = REQ_WIDTH'(REQ_COUNT - 1);

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [REQ_WIDTH-1:0] rr_ptr;
  logic [CNT_W-1:0]     counter;

  logic                 pick_valid;
  logic [REQ_WIDTH-1:0] pick_idx;
  logic [31:0]          sel_cmd;
  logic [31:0]          sel_wr_data;
  logic                 accept;
  logic                 resp_hs;
  logic [REQ_WIDTH-1:0] rr_next;

  host_cmd_rr_pick #(
    .REQ_COUNT (REQ_COUNT),
    .REQ_WIDTH (REQ_WIDTH)
  ) u_pick (
    .req         (req_valid),
    .rr_ptr      (rr_ptr),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // A request is taken only in IDLE, and never while reset is held so a
  // requester cannot believe it was served by a block that is being cleared
  assign accept = sys_rst_n && (state == ST_IDLE) && pick_valid;

  // Steer the winning requester's command and write data
  always_comb begin
    sel_cmd     = '0;
    sel_wr_data = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (pick_idx == REQ_WIDTH'(i)) begin
        sel_cmd     = req_cmd[i*32 +: 32];
        sel_wr_data = req_wr_data[i*32 +: 32];
      end
    end
  end

  // One-hot ready to the winner and one-hot response valid to the grantee
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      req_ready[i]  = accept && (pick_idx == REQ_WIDTH'(i));
      resp_valid[i] = (state == ST_RESP) && (grant_id == REQ_WIDTH'(i));
    end
  end

  // Only the grantee's ready can complete the response
  assign resp_hs = |(resp_valid & resp_ready);

  assign host_cmd_valid = (state == ST_ISSUE);
  assign busy           = (state != ST_IDLE);
  assign rr_next        = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = cmd_is_write(host_cmd) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (counter == '0) state_next = ST_RESP;
      ST_RESP:  if (resp_hs) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Latch the accepted command; it stays put until the next acceptance so
  // the address-driven readback mux downstream sees a stable command
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      host_cmd         <= '0;
      host_cmd_wr_data <= '0;
      grant_id         <= '0;
    end else if (accept) begin
      host_cmd         <= sel_cmd;
      host_cmd_wr_data <= sel_wr_data;
      grant_id         <= pick_idx;
    end
  end

  // Readback latency counter: loaded at issue, ends WAIT when it hits zero
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      counter <= '0;
    else if (state == ST_ISSUE)
      counter <= CNT_LOAD;
    else if ((state == ST_WAIT) && (counter != '0))
      counter <= counter - 1'b1;
  end

  // Response data: zero for write acks, sampled readback for reads
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      resp_data <= '0;
    else if ((state == ST_ISSUE) && cmd_is_write(host_cmd))
      resp_data <= '0;
    else if ((state == ST_WAIT) && (counter == '0))
      resp_data <= host_cmd_rd_data;
  end

  // Advance the round-robin pointer past the requester just served
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      rr_ptr <= '0;
    else if ((state == ST_RESP) && resp_hs)
      rr_ptr <= rr_next;
  end

endmodule

// File: tb/tb_host_cmd_arbiter.sv
// Testbench for host_cmd_arbiter: directed scenarios plus a randomized
// transaction run checked against a transaction-level round-robin model.
module tb_host_cmd_arbiter;

  localparam int REQ_COUNT  = 2;
  localparam int RD_LATENCY = 16;
  localparam int REQ_WIDTH  = 1;

  logic                    sys_clk;
  logic                    sys_rst_n;
  logic [REQ_COUNT*32-1:0] req_cmd;
  logic [REQ_COUNT*32-1:0] req_wr_data;
  logic [REQ_COUNT-1:0]    req_valid;
  logic [REQ_COUNT-1:0]    req_ready;
  logic [31:0]             resp_data;
  logic [REQ_COUNT-1:0]    resp_valid;
  logic [REQ_COUNT-1:0]    resp_ready;
  logic [31:0]             host_cmd;
  logic [31:0]             host_cmd_wr_data;
  logic                    host_cmd_valid;
  logic [31:0]             host_cmd_rd_data;
  logic [REQ_WIDTH-1:0]    grant_id;
  logic                    busy;

  int n_checks;
  int n_fail;

  // Transaction-level model state for the randomized run
  logic        m_pend [REQ_COUNT];
  logic [31:0] m_cmd  [REQ_COUNT];
  logic [31:0] m_wd   [REQ_COUNT];

  host_cmd_arbiter #(
    .REQ_COUNT  (REQ_COUNT),
    .RD_LATENCY (RD_LATENCY),
    .REQ_WIDTH  (REQ_WIDTH)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .req_cmd          (req_cmd),
    .req_wr_data      (req_wr_data),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .resp_data        (resp_data),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .host_cmd         (host_cmd),
    .host_cmd_wr_data (host_cmd_wr_data),
    .host_cmd_valid   (host_cmd_valid),
    .host_cmd_rd_data (host_cmd_rd_data),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_rst_n        = 1'b0;
    req_valid        = '0;
    req_cmd          = '0;
    req_wr_data      = '0;
    resp_ready       = '0;
    host_cmd_rd_data = '0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    tick();
  endtask

  // Run one complete write for requester r from IDLE (r must be the winner)
  task automatic run_write(input int r, input logic [31:0] cmd, input logic [31:0] wd);
    req_valid                = '0;
    req_valid[r]             = 1'b1;
    req_cmd[r*32 +: 32]      = cmd;
    req_wr_data[r*32 +: 32]  = wd;
    tick();
    req_valid = '0;
    tick();
    resp_ready    = '0;
    resp_ready[r] = 1'b1;
    tick();
    resp_ready = '0;
  endtask

  task automatic test_reset();
    sys_rst_n   = 1'b1;
    req_valid   = '0;
    req_cmd     = {32'h8000_0055, 32'h0000_0066};
    req_wr_data = {32'h1111_1111, 32'h2222_2222};
    resp_ready  = '0;
    host_cmd_rd_data = 32'h5555_AAAA;
    #3 sys_rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    n_checks++; if (host_cmd !== 32'h0) begin n_fail++; $display("FAIL reset_host_cmd: got %h expected %h", host_cmd, 32'h0); end
    n_checks++; if (host_cmd_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected %h", host_cmd_wr_data, 32'h0); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected %h", resp_data, 32'h0); end
    n_checks++; if (host_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", host_cmd_valid); end
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single_read();
    apply_reset();
    req_cmd[31:0] = 32'h0000_0013;
    req_valid     = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_req_ready: got %b expected 01", req_ready); end
    tick();  // T+1
    req_valid = '0;
    #1;
    n_checks++; if (host_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_cmd_valid: got %b expected 1", host_cmd_valid); end
    n_checks++; if (host_cmd !== 32'h0000_0013) begin n_fail++; $display("FAIL rd_host_cmd: got %h expected %h", host_cmd, 32'h13); end
    for (int c = 2; c <= RD_LATENCY + 1; c++) begin
      tick();
      host_cmd_rd_data = (c == RD_LATENCY + 1) ? 32'hCAFE_0001 : (32'hDEAD_0000 | c);
      #1;
      n_checks++;
      if (host_cmd_valid !== 1'b0 || resp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL rd_wait_quiet: cycle T+%0d got cmd_valid=%b resp_valid=%b expected 0/00", c, host_cmd_valid, resp_valid);
      end
    end
    tick();  // T+2+RD_LATENCY
    host_cmd_rd_data = 32'h0;
    #1;
    n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_resp_valid: got %b expected 01", resp_valid); end
    n_checks++; if (resp_data !== 32'hCAFE_0001) begin n_fail++; $display("FAIL rd_resp_data: got %h expected %h", resp_data, 32'hCAFE_0001); end
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle_after: got busy=%b expected 0", busy); end
  endtask

  task automatic test_write_ack();
    apply_reset();
    req_cmd[63:32]     = 32'hA000_0000;
    req_wr_data[63:32] = 32'h0000_0007;
    req_valid          = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL wr_req_ready: got %b expected 10", req_ready); end
    tick();  // T+1
    req_valid = '0;
    #1;
    n_checks++; if (host_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_valid: got %b expected 1", host_cmd_valid); end
    n_checks++; if (host_cmd_wr_data !== 32'h7) begin n_fail++; $display("FAIL wr_wr_data: got %h expected %h", host_cmd_wr_data, 32'h7); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL wr_grant_id: got %0d expected 1", grant_id); end
    tick();  // T+2
    #1;
    n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL wr_resp_valid: got %b expected 10", resp_valid); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL wr_resp_data: got %h expected 0", resp_data); end
    resp_ready = 2'b10;
    tick();
    resp_ready = '0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle_after: got busy=%b expected 0", busy); end
    n_checks++; if (host_cmd !== 32'hA000_0000) begin n_fail++; $display("FAIL wr_cmd_hold: got %h expected %h", host_cmd, 32'hA000_0000); end
  endtask

  task automatic test_contention();
    int          pulse_cyc [$];
    int          pulse_gid [$];
    logic [31:0] pulse_cmd [$];
    logic [31:0] exp_cmd;
    apply_reset();
    req_cmd    = {32'h8000_0011, 32'h8000_0010};
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    for (int c = 1; c <= 30; c++) begin
      tick();
      #1;
      if (host_cmd_valid === 1'b1) begin
        pulse_cyc.push_back(c);
        pulse_gid.push_back(int'(grant_id));
        pulse_cmd.push_back(host_cmd);
      end
    end
    req_valid  = '0;
    resp_ready = '0;
    n_checks++; if (pulse_cyc.size() != 10) begin n_fail++; $display("FAIL cont_pulse_count: got %0d expected 10", pulse_cyc.size()); end
    for (int k = 0; k < pulse_cyc.size(); k++) begin
      exp_cmd = (k % 2 == 0) ? 32'h8000_0010 : 32'h8000_0011;
      n_checks++; if (pulse_gid[k] != k % 2) begin n_fail++; $display("FAIL cont_grant[%0d]: got %0d expected %0d", k, pulse_gid[k], k % 2); end
      n_checks++; if (pulse_cmd[k] !== exp_cmd) begin n_fail++; $display("FAIL cont_cmd[%0d]: got %h expected %h", k, pulse_cmd[k], exp_cmd); end
      if (k > 0) begin
        n_checks++; if (pulse_cyc[k] - pulse_cyc[k-1] != 3) begin n_fail++; $display("FAIL cont_spacing[%0d]: got %0d expected 3", k, pulse_cyc[k] - pulse_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_cmd     = {32'h8000_0099, 32'h0000_0020};
    req_wr_data = {32'h0000_0042, 32'h0};
    req_valid   = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_req_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b10;
    for (int k = 1; k <= RD_LATENCY; k++) begin
      tick();
      host_cmd_rd_data = (k == RD_LATENCY) ? 32'h1234_5678 : 32'h0BAD_0000;
    end
    tick();
    host_cmd_rd_data = 32'hFFFF_FFFF;
    for (int s = 0; s < 10; s++) begin
      #1;
      n_checks++;
      if (resp_valid !== 2'b01 || resp_data !== 32'h1234_5678 || host_cmd_valid !== 1'b0 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got resp_valid=%b data=%h cmd_valid=%b req_ready=%b expected 01/12345678/0/00",
                 s, resp_valid, resp_data, host_cmd_valid, req_ready);
      end
      tick();
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_after: got busy=%b expected 0", busy); end
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_next_winner: got %b expected 10", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_wrong_ready();
    apply_reset();
    req_cmd[31:0]     = 32'h8000_0001;
    req_wr_data[31:0] = 32'h0000_0005;
    req_valid         = 2'b01;
    tick();
    req_valid = '0;
    tick();  // RESP
    resp_ready = 2'b10;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_checks++;
      if (resp_valid !== 2'b01 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL wrong_ready[%0d]: got resp_valid=%b busy=%b expected 01/1", s, resp_valid, busy);
      end
      tick();
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    #1;
    n_checks++; if (resp_valid !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL wrong_ready_done: got resp_valid=%b busy=%b expected 00/0", resp_valid, busy); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    run_write(0, 32'h8000_0003, 32'h0000_0001);  // pointer now favours requester 1
    req_cmd[63:32] = 32'h0000_0044;
    req_valid      = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rmw_req_ready: got %b expected 10", req_ready); end
    tick();  // T+1
    req_valid = '0;
    repeat (4) tick();  // T+5
    sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (host_cmd !== 32'h0 || busy !== 1'b0 || host_cmd_valid !== 1'b0 || grant_id !== 1'b0 || resp_valid !== 2'b00 || resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rmw_outputs: got cmd=%h busy=%b cmd_valid=%b gid=%0d resp_valid=%b data=%h expected all 0",
               host_cmd, busy, host_cmd_valid, grant_id, resp_valid, resp_data);
    end
    tick();
    sys_rst_n = 1'b1;
    for (int c = 0; c < RD_LATENCY + 4; c++) begin
      host_cmd_rd_data = $urandom;
      tick();
      n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL rmw_no_resp[%0d]: got %b expected 00", c, resp_valid); end
    end
    req_cmd   = {32'h8000_0002, 32'h8000_0001};
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmw_rr_restart: got %b expected 01", req_ready); end
    req_valid = '0;
  endtask

  task automatic drive_pending();
    for (int i = 0; i < REQ_COUNT; i++) begin
      req_valid[i]            = m_pend[i];
      req_cmd[i*32 +: 32]     = m_pend[i] ? m_cmd[i] : $urandom;
      req_wr_data[i*32 +: 32] = m_pend[i] ? m_wd[i]  : $urandom;
    end
  endtask

  task automatic new_request(input int i);
    m_pend[i] = 1'b1;
    m_cmd[i]  = $urandom;
    m_wd[i]   = $urandom;
  endtask

  task automatic test_random();
    int                  rr_m;
    int                  w;
    int                  idx;
    int                  stall;
    int                  any;
    logic                is_wr;
    logic [31:0]         exp_rd;
    logic [31:0]         exp_resp;
    logic [31:0]         cur_cmd;
    logic [31:0]         cur_wd;
    logic [REQ_COUNT-1:0] exp_oh;
    apply_reset();
    rr_m = 0;
    for (int i = 0; i < REQ_COUNT; i++) m_pend[i] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      // Requesters come and go while the arbiter is idle
      for (int i = 0; i < REQ_COUNT; i++) begin
        if (!m_pend[i]) begin
          if ($urandom_range(0, 1) == 1) new_request(i);
        end else if ($urandom_range(0, 9) == 0) begin
          m_pend[i] = 1'b0;
        end
      end
      any = 0;
      for (int i = 0; i < REQ_COUNT; i++) if (m_pend[i]) any = 1;
      if (any == 0) new_request($urandom_range(0, REQ_COUNT - 1));
      drive_pending();
      w = -1;
      for (int k = 0; k < REQ_COUNT; k++) begin
        idx = (rr_m + k) % REQ_COUNT;
        if (w < 0 && m_pend[idx]) w = idx;
      end
      exp_oh    = '0;
      exp_oh[w] = 1'b1;
      cur_cmd   = m_cmd[w];
      cur_wd    = m_wd[w];
      is_wr     = cur_cmd[31];
      #1;
      n_checks++; if (req_ready !== exp_oh || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_accept[%0d]: got ready=%b busy=%b expected %b/0", t, req_ready, busy, exp_oh); end
      tick();  // ISSUE
      m_pend[w] = 1'b0;
      drive_pending();
      #1;
      n_checks++;
      if (host_cmd_valid !== 1'b1 || host_cmd !== cur_cmd || host_cmd_wr_data !== cur_wd || grant_id !== REQ_WIDTH'(w) || req_ready !== '0) begin
        n_fail++;
        $display("FAIL rnd_issue[%0d]: got valid=%b cmd=%h wd=%h gid=%0d ready=%b expected 1/%h/%h/%0d/0",
                 t, host_cmd_valid, host_cmd, host_cmd_wr_data, grant_id, req_ready, cur_cmd, cur_wd, w);
      end
      exp_rd = $urandom;
      if (!is_wr) begin
        for (int k = 1; k <= RD_LATENCY; k++) begin
          tick();
          host_cmd_rd_data = (k == RD_LATENCY) ? exp_rd : $urandom;
          if (k == 3) begin
            for (int i = 0; i < REQ_COUNT; i++)
              if (!m_pend[i] && $urandom_range(0, 1) == 1) new_request(i);
            drive_pending();
          end
          #1;
          n_checks++;
          if (host_cmd_valid !== 1'b0 || host_cmd !== cur_cmd || req_ready !== '0 || resp_valid !== '0) begin
            n_fail++;
            $display("FAIL rnd_wait[%0d.%0d]: got valid=%b cmd=%h ready=%b resp_valid=%b expected 0/%h/0/0",
                     t, k, host_cmd_valid, host_cmd, req_ready, resp_valid, cur_cmd);
          end
        end
      end
      tick();  // RESP
      host_cmd_rd_data = $urandom;
      exp_resp = is_wr ? 32'h0 : exp_rd;
      #1;
      n_checks++; if (resp_valid !== exp_oh || resp_data !== exp_resp) begin n_fail++; $display("FAIL rnd_resp[%0d]: got valid=%b data=%h expected %b/%h", t, resp_valid, resp_data, exp_oh, exp_resp); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        resp_ready = REQ_COUNT'($urandom) & ~exp_oh;
        tick();
        #1;
        n_checks++; if (resp_valid !== exp_oh || resp_data !== exp_resp || host_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_hold[%0d.%0d]: got valid=%b data=%h cmd_valid=%b expected %b/%h/0", t, s, resp_valid, resp_data, host_cmd_valid, exp_oh, exp_resp); end
      end
      resp_ready = exp_oh | REQ_COUNT'($urandom);
      tick();
      resp_ready = '0;
      rr_m = (w + 1) % REQ_COUNT;
    end
    req_valid = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sys_rst_n        = 1'b1;
    req_valid        = '0;
    req_cmd          = '0;
    req_wr_data      = '0;
    resp_ready       = '0;
    host_cmd_rd_data = '0;
    test_reset();
    test_single_read();
    test_write_ack();
    test_contention();
    test_backpressure();
    test_wrong_ready();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before the end of test");
    $fatal(1);
  end

endmodule

// File: doc/host_cmd_arbiter.md
Name: host_cmd_arbiter

Overview:
Shares the single host command/readback port of the command-and-status subsystem among several requesters, such as the PCIe register path, a debug/JTAG bridge and a periodic stat poller.
- Serialises commands and issues each as a one-cycle `host_cmd_valid` pulse.
- For reads, waits a fixed pipeline latency, then samples `host_cmd_rd_data` and routes it back to the winning requester.
- Sits in the `sys_clk` domain, directly in front of the command/status block.

Parameters:
- REQ_COUNT, 2, number of requesters (≥1).
- RD_LATENCY, 16, cycles from the `host_cmd_valid` cycle to the cycle in which `host_cmd_rd_data` is valid (≥1). It must cover the worst-case (RPU, clock-crossed) readback path.
- REQ_WIDTH, $clog2(REQ_COUNT) (minimum 1), width of the requester index.

Ports:
- sys_clk  in  1  block clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req_cmd  in  REQ_COUNT*32  per-requester command word; bit 31 = write, bits 30:29 = target.
- req_wr_data  in  REQ_COUNT*32  per-requester write data.
- req_valid  in  REQ_COUNT  request pending.
- req_ready  out  REQ_COUNT  request accepted (one-hot, combinational).
- resp_data  out  32  read data; 0 for write acks.
- resp_valid  out  REQ_COUNT  one-hot response valid.
- resp_ready  in  REQ_COUNT  response consumed.
- host_cmd  out  32  command to the status subsystem.
- host_cmd_wr_data  out  32  write data to the status subsystem.
- host_cmd_valid  out  1  single-cycle command strobe.
- host_cmd_rd_data  in  32  readback data.
- grant_id  out  REQ_WIDTH  index of the current/last granted requester.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; rr_ptr = 0; counter = 0.
  - `host_cmd`, `host_cmd_wr_data`, `resp_data` = 0.
  - `host_cmd_valid`, `resp_valid`, `busy`, `grant_id` = 0.
  - A transaction in flight at reset is abandoned; no response is produced.
- Arbitration (IDLE only):
  - Round-robin, searching from rr_ptr upward with wrap.
  - `req_ready[g]` = 1 only for the winner g, only in IDLE, and only while `req_valid[g]` = 1.
  - On acceptance: latch `req_cmd[g]` and `req_wr_data[g]` into `host_cmd`/`host_cmd_wr_data`, set `grant_id` = g, go to ISSUE.
- ISSUE (1 cycle):
  - `host_cmd_valid` = 1.
  - If cmd bit31 = 1 (write): `resp_data` ← 0, go to RESP.
  - Else (read): counter ← RD_LATENCY-1, go to WAIT.
- WAIT:
  - If counter == 0: `resp_data` ← `host_cmd_rd_data`, go to RESP.
  - Else: counter decrements.
  - `host_cmd` stays stable throughout, because the readback mux downstream is address-driven.
- RESP:
  - `resp_valid[grant_id]` = 1; `resp_data` is held until `resp_ready[grant_id]` = 1.
  - On that handshake: rr_ptr ← grant_id+1 (wrap to 0 at REQ_COUNT), go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- Latency, with acceptance in cycle T:
  - `host_cmd_valid` in T+1.
  - Write: `resp_valid` from T+2.
  - Read: data sampled at T+1+RD_LATENCY; `resp_valid` from T+2+RD_LATENCY.
  - Minimum issue spacing is 3 cycles (writes) and RD_LATENCY+3 cycles (reads); no new issue happens while busy.
- Outputs after a transaction:
  - `host_cmd` and `host_cmd_wr_data` hold their last value after issue.
  - `host_cmd_valid` is never asserted outside ISSUE.
- Boundaries:
  - Requests arriving in the same cycle: the one nearest rr_ptr wins; the others keep `req_valid` asserted and are served in later IDLE cycles.
  - A requester dropping `req_valid` before acceptance is legal.
  - REQ_COUNT = 1 degenerates to a pass-through sequencer with grant_id = 0.
  - RD_LATENCY = 1: WAIT lasts exactly one cycle.

Decomposition:
- Shared package (`host_cmd_pkg`):
  - State encoding: IDLE, ISSUE, WAIT, RESP.
  - CMD_WR_BIT = 31; CMD_TGT_MSB = 30; CMD_TGT_LSB = 29.
  - Target codes: TGT_RPU = 2'b00, TGT_INT = 2'b01, TGT_LB = 2'b1x.
- Sub-module `host_cmd_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, rr_ptr.
  - Outputs: `grant_valid`, `grant_idx`.
  - Reusable elsewhere for other host-port sharing.

Test Plan:
- Reset mid-WAIT: read issued, `sys_rst_n` pulsed low at T+5 → all outputs 0 immediately; no `resp_valid` after release; next request issues normally from rr_ptr = 0.
- Single read, RD_LATENCY = 16: req0 cmd = 0x0000_0013 accepted at T; `host_cmd_rd_data` driven to 0xCAFE_0001 only at T+17 → `host_cmd_valid` at T+1 only; `resp_valid` = 2'b01 at T+18 with `resp_data` = 0xCAFE_0001.
- Write ack: req1 cmd = 0xA000_0000, wr_data = 0x7 → `host_cmd_valid` at T+1 with `host_cmd_wr_data` = 0x7; `resp_valid` = 2'b10 at T+2 with `resp_data` = 0.
- Contention/fairness: both requesters continuously valid with writes → grants alternate 0,1,0,1; `host_cmd_valid` pulses spaced exactly 3 cycles apart.
- Response backpressure: `resp_ready` held low for 10 cycles → `resp_valid` and `resp_data` stable; no `host_cmd_valid` and `req_ready` = 0 throughout; IDLE one cycle after `resp_ready`.
- Wrong-requester ready: `resp_valid` = 2'b01 while only `resp_ready[1]` = 1 → response not consumed; it remains pending.
